rpsc_interlock_filter: RTL
==========================

RPSC_INTERLOCK_FILTER -- requirements
Module: rpsc_interlock_filter

Interface
REQ-001 SHALL have parameter: test_mode, 0, selects short debounce (1) or field debounce (0).
REQ-002 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port: fault_raw  input  7  raw interlock contacts, active-high; [6]Card_POS [5]Air_Grid [4]Water_Anode [3]Water_Grid [2]DC_PS [1]U_CA_Low [0]I_CA_High.
REQ-005 SHALL have port: ack  input  1  operator fault-acknowledge, asynchronous level.
REQ-006 SHALL have port: fault_out  output  7  debounced and latched faults, same bit order; feeds the card-1 status inputs.
REQ-007 SHALL have port: first_fault  output  3  code of first latched channel: bit index + 1; 0 = none.
REQ-008 SHALL have port: not_alarm  output  1  high when no bit of fault_out is set.

Function
REQ-009 SHALL pass each fault_raw bit and ack through a 2-flop synchronizer before any other use.
REQ-010 SHALL keep per channel a filtered state and a debounce counter; DB_CYCLES = 4 when test_mode=1, 781 when test_mode=0.
REQ-011 Counter SHALL increment on each edge where the synchronized input differs from the filtered state, and SHALL clear to 0 on any edge where they are equal.
REQ-012 Filtered state SHALL invert, and the counter clear, on the edge where the counter equals DB_CYCLES-1 and the input still differs.
REQ-013 Latency: a raw change held stable SHALL change the filtered state exactly DB_CYCLES+2 rising edges after the first edge that samples it; shorter pulses SHALL have no effect.
REQ-014 Latch bit i SHALL set on the same edge filtered[i] rises; fault_out = latch register (no extra cycle).
REQ-015 Latch bit i SHALL clear only on an edge where a synchronized ack rising edge is detected and filtered[i] is 0; channels still active SHALL remain latched.
REQ-016 Set SHALL take priority over clear when both occur on the same edge for a channel.
REQ-017 first_fault SHALL load on the edge where any latch sets while all latches were clear; among simultaneous sets, the highest bit index wins.
REQ-018 first_fault SHALL hold while any latch is set and SHALL return to 0 on the edge all latches become clear.
REQ-019 not_alarm SHALL be the combinational NOR of fault_out.
REQ-020 An ack held high SHALL count as one acknowledge only; re-acknowledge SHALL require ack to go low and high again.

Reset
REQ-021 While reset=0, all synchronizers, counters, filtered states, latches and first_fault SHALL be 0; hence fault_out=0, first_fault=0, not_alarm=1.
REQ-022 Reset asserted mid-debounce or with faults latched SHALL discard all state immediately (asynchronous); after release, a still-active input SHALL re-qualify with full DB_CYCLES+2 latency.

Structure
REQ-023 Shared package rpsc_pkg SHALL hold NUM_CH=7, channel index constants, DB_CYCLES_TEST=4, DB_CYCLES_FIELD=781 and counter width 10.
REQ-024 Per-channel synchronizer+debounce SHALL be a sub-module rpsc_debounce_ch, instantiated 7 times with a generate loop; latch and first-fault logic stay in the top.

Verification (test_mode=1, DB_CYCLES=4)
REQ-025 fault_raw[2] high for 3 cycles then low -> fault_out stays 0, not_alarm stays 1.
REQ-026 fault_raw[2] high and held -> fault_out=7'b0000100 from edge 6 after first sample, first_fault=3, not_alarm=0.
REQ-027 fault_raw[2] still high, ack pulse -> fault_out unchanged; drop fault_raw[2], wait 8 cycles, ack pulse -> fault_out=0, first_fault=0 within 4 edges of ack.
REQ-028 fault_raw[3] and fault_raw[1] rise on same cycle -> fault_out=7'b0001010, first_fault=4; later fault_raw[5] -> first_fault stays 4.
REQ-029 Faults latched, reset driven 0 between clock edges -> all outputs return to reset values immediately; after release with fault_raw[0] held, fault_out[0] re-asserts 6 edges later.
REQ-030 ack held high across two fault episodes -> second episode not cleared until ack toggles low then high.

Source files
------------

// File: rtl/rpsc_pkg.sv
// Shared constants and helpers for the RPSC interlock filter.
package rpsc_pkg;

   localparam int NUM_CH = 7;

   localparam int CH_I_CA_HIGH    = 0;
   localparam int CH_U_CA_LOW     = 1;
   localparam int CH_DC_PS        = 2;
   localparam int CH_WATER_GRID   = 3;
   localparam int CH_WATER_ANODE  = 4;
   localparam int CH_AIR_GRID     = 5;
   localparam int CH_CARD_POS     = 6;

   localparam int DB_CYCLES_TEST  = 4;
   localparam int DB_CYCLES_FIELD = 781;
   localparam int CNT_W           = 10;

   typedef logic [NUM_CH-1:0] ch_vec_t;
   typedef logic [2:0]        ff_code_t;

   // Highest set channel wins; the code is bit index + 1 so that 0 means "none".
   function automatic ff_code_t first_code(input ch_vec_t v);
      ff_code_t code;
      code = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (v[i]) code = ff_code_t'(i + 1);
      end
      return code;
   endfunction

endpackage

// File: rtl/rpsc_debounce_ch.sv
// One interlock channel: two-flop synchronizer followed by a debounce counter
// that flips the filtered state after the synchronized input has disagreed
// with it for DB_CYCLES consecutive edges.
module rpsc_debounce_ch
   import rpsc_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DB_CYCLES_FIELD
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic filtered,
   output logic rise
);

   localparam logic [CNT_W-1:0] TC = CNT_W'(DB_CYCLES - 1);

   logic             sync_1;
   logic             sync_2;
   logic [CNT_W-1:0] cnt;
   logic             differ;
   logic             terminal;

   assign differ   = sync_2 ^ filtered;
   assign terminal = differ && (cnt == TC);
   // Combinational so the latch in the top can set on the very edge the
   // filtered state goes high.
   assign rise     = terminal & ~filtered;

   // Metastability guard on the raw contact.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
      end
   end

   // Debounce: count disagreement, any agreement restarts the count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt      <= '0;
         filtered <= 1'b0;
      end else if (!differ) begin
         cnt      <= '0;
      end else if (terminal) begin
         cnt      <= '0;
         filtered <= ~filtered;
      end else begin
         cnt      <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/rpsc_interlock_filter.sv
// RPSC interlock filter: per-channel debounce, fault latching with operator
// acknowledge, and first-fault capture for the card-1 status inputs.
module rpsc_interlock_filter
   import rpsc_pkg::*;
#(
   parameter bit test_mode = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] fault_raw,
   input  logic              ack,
   output logic [NUM_CH-1:0] fault_out,
   output logic [2:0]        first_fault,
   output logic              not_alarm
);

   localparam int unsigned DB_CYCLES = test_mode ? DB_CYCLES_TEST : DB_CYCLES_FIELD;

   ch_vec_t filtered;
   ch_vec_t rise;
   ch_vec_t latch;
   ch_vec_t latch_clr;
   ch_vec_t latch_next;

   logic ack_s1;
   logic ack_s2;
   logic ack_d;
   logic ack_edge;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      rpsc_debounce_ch #(
         .DB_CYCLES (DB_CYCLES)
      ) u_ch (
         .clk      (clk),
         .reset    (reset),
         .raw      (fault_raw[g]),
         .filtered (filtered[g]),
         .rise     (rise[g])
      );
   end

   // Synchronize ack and keep one delayed copy so a held level acks only once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack_s1 <= 1'b0;
         ack_s2 <= 1'b0;
         ack_d  <= 1'b0;
      end else begin
         ack_s1 <= ack;
         ack_s2 <= ack_s1;
         ack_d  <= ack_s2;
      end
   end

   assign ack_edge = ack_s2 & ~ack_d;

   // Only channels whose filtered input has gone quiet may be released; a new
   // rise on the same edge outranks the release.
   assign latch_clr  = {NUM_CH{ack_edge}} & ~filtered;
   assign latch_next = rise | (latch & ~latch_clr);

   // Fault latch and first-fault capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         latch       <= '0;
         first_fault <= '0;
      end else begin
         latch <= latch_next;
         if (latch_next == '0) begin
            first_fault <= '0;
         end else if (latch == '0) begin
            first_fault <= first_code(rise);
         end
      end
   end

   assign fault_out = latch;
   assign not_alarm = ~|latch;

endmodule
